program_arbiter: RTL and testbench

Two-port Avalon-MM arbiter that shares one downstream memory-mapped slave, such as the program-logic register file with its `s0_*` port, between two independent requesters. Each requester sees a standard Avalon slave port with `waitrequest` back-pressure. Grants use round-robin order and are held until the downstream transfer completes. A watchdog aborts transfers whose downstream `waitrequest` never drops, so a hung slave cannot lock the bus.

---
 rtl/program_arbiter_pkg.sv | 26 ++
 rtl/rr_select2.sv | 13 +
 rtl/program_arbiter.sv | 142 ++++++++++++++
 tb/tb_program_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_arbiter_pkg.sv
// Shared types and helpers for the two-port Avalon-MM program arbiter.
// Holds the FSM state enum, the default abort read data and a clog2 helper.
package program_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Width needed to hold values 0..v-1; never returns less than 1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_select2.sv
// Two-way round-robin selector, purely combinational.
// Ports: act0_i/act1_i requester active, last_grant_i previous winner, grant_o next winner.
module rr_select2 (
    input  logic act0_i,
    input  logic act1_i,
    input  logic last_grant_i,
    output logic grant_o
);

    // A tie goes to whoever did not win last; otherwise the lone active one.
    assign grant_o = (act0_i & act1_i) ? ~last_grant_i : act1_i;

endmodule

// File: rtl/program_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave between two requesters,
// with a per-transfer watchdog that aborts hung downstream transfers.
// Ports: r0_*/r1_* requester slave ports, m_* downstream master port,
// timeout_clear/timeout_flag sticky abort indication, clk/reset (async, low).
module program_arbiter
    import program_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    TIMEOUT      = 1024,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(DEF_TIMEOUT_DATA)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] r0_address,
    input  logic                  r0_read,
    input  logic                  r0_write,
    input  logic [DATA_WIDTH-1:0] r0_writedata,
    output logic [DATA_WIDTH-1:0] r0_readdata,
    output logic                  r0_waitrequest,
    input  logic [ADDR_WIDTH-1:0] r1_address,
    input  logic                  r1_read,
    input  logic                  r1_write,
    input  logic [DATA_WIDTH-1:0] r1_writedata,
    output logic [DATA_WIDTH-1:0] r1_readdata,
    output logic                  r1_waitrequest,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic                  m_read,
    output logic                  m_write,
    output logic [DATA_WIDTH-1:0] m_writedata,
    input  logic [DATA_WIDTH-1:0] m_readdata,
    input  logic                  m_waitrequest,
    input  logic                  timeout_clear,
    output logic                  timeout_flag
);

    localparam int TW = clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_q, last_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            flag_q, flag_d;

    logic            act0, act1, sel;
    logic            busy, g_rd, g_wr, g_req;
    logic            abort, done;
    logic [DATA_WIDTH-1:0] resp_data;
    logic            resp_wait;

    assign act0 = r0_read | r0_write;
    assign act1 = r1_read | r1_write;

    rr_select2 u_sel (
        .act0_i       (act0),
        .act1_i       (act1),
        .last_grant_i (last_q),
        .grant_o      (sel)
    );

    assign busy  = (state_q == BUSY);
    assign g_rd  = grant_q ? r1_read  : r0_read;
    assign g_wr  = grant_q ? r1_write : r0_write;
    assign g_req = g_rd | g_wr;

    // Watchdog fires on the last permitted stall cycle.
    assign abort = busy & g_req & m_waitrequest
                 & (timer_q == TW'(TIMEOUT - 1));
    assign done  = busy & g_req & ~m_waitrequest;

    assign resp_wait = abort ? 1'b0 : m_waitrequest;
    assign resp_data = abort ? TIMEOUT_DATA : m_readdata;

    assign timeout_flag = flag_q;

    always_comb begin
        m_address      = grant_q ? r1_address   : r0_address;
        m_writedata    = grant_q ? r1_writedata : r0_writedata;
        m_read         = busy & g_rd & ~abort;
        m_write        = busy & g_wr & ~abort;
        r0_waitrequest = 1'b1;
        r1_waitrequest = 1'b1;
        r0_readdata    = '0;
        r1_readdata    = '0;
        if (busy) begin
            if (grant_q) begin
                r1_waitrequest = resp_wait;
                r1_readdata    = resp_data;
            end else begin
                r0_waitrequest = resp_wait;
                r0_readdata    = resp_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        timer_d = timer_q;
        flag_d  = flag_q;
        if (timeout_clear) flag_d = 1'b0;
        if (abort)         flag_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (act0 | act1) begin
                    state_d = BUSY;
                    grant_d = sel;
                    timer_d = '0;
                end
            end
            BUSY: begin
                if (!g_req) begin
                    // Withdrawn request: drop it without crediting the grant.
                    state_d = IDLE;
                end else if (done | abort) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else if (timer_q != TW'(TIMEOUT)) begin
                    timer_d = timer_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            timer_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            flag_q  <= flag_d;
        end
    end

endmodule

// File: tb/tb_program_arbiter.sv
// Self-checking bench for program_arbiter: directed protocol scenarios
// followed by randomized traffic against a scoreboard and reference memory.
module tb_program_arbiter;

    localparam int          TO    = 8;
    localparam logic [31:0] TDATA = 32'hDEAD_BEEF;
    localparam int          NTX   = 150;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] r0_address = '0, r1_address = '0;
    logic        r0_read = 1'b0, r0_write = 1'b0;
    logic        r1_read = 1'b0, r1_write = 1'b0;
    logic [31:0] r0_writedata = '0, r1_writedata = '0;
    logic [31:0] r0_readdata, r1_readdata;
    logic        r0_waitrequest, r1_waitrequest;
    logic [31:0] m_address, m_writedata, m_readdata;
    logic        m_read, m_write, m_waitrequest;
    logic        timeout_clear = 1'b0;
    logic        timeout_flag;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    program_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .TIMEOUT      (TO),
        .TIMEOUT_DATA (TDATA)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .r0_address     (r0_address),
        .r0_read        (r0_read),
        .r0_write       (r0_write),
        .r0_writedata   (r0_writedata),
        .r0_readdata    (r0_readdata),
        .r0_waitrequest (r0_waitrequest),
        .r1_address     (r1_address),
        .r1_read        (r1_read),
        .r1_write       (r1_write),
        .r1_writedata   (r1_writedata),
        .r1_readdata    (r1_readdata),
        .r1_waitrequest (r1_waitrequest),
        .m_address      (m_address),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_writedata    (m_writedata),
        .m_readdata     (m_readdata),
        .m_waitrequest  (m_waitrequest),
        .timeout_clear  (timeout_clear),
        .timeout_flag   (timeout_flag)
    );

    // ---------------- downstream slave model ----------------
    logic [31:0] mem [64];
    logic [31:0] init_mem [64];
    int          stall_of [64];
    int          stall_cnt;
    logic        load = 1'b0;
    logic [5:0]  sa;

    assign sa = m_address[5:0];

    // Stall depends only on the slave's own counter, never on m_read/m_write.
    always_comb begin
        m_waitrequest = (stall_cnt < stall_of[sa]);
        m_readdata    = mem[sa];
    end

    always @(posedge clk) begin
        if (!reset || !((m_read | m_write) && m_waitrequest))
            stall_cnt <= 0;
        else
            stall_cnt <= stall_cnt + 1;
        if (load) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
        end else if (m_write && !m_waitrequest) begin
            mem[sa] <= m_writedata;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_all();
        r0_read = 1'b0; r0_write = 1'b0;
        r1_read = 1'b0; r1_write = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load_mem();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic set_req(input int p, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            r0_read = rd; r0_write = wr; r0_address = a; r0_writedata = d;
        end else begin
            r1_read = rd; r1_write = wr; r1_address = a; r1_writedata = d;
        end
    endtask

    function automatic logic wq(input int p);
        return (p == 0) ? r0_waitrequest : r1_waitrequest;
    endfunction

    function automatic logic rq(input int p);
        return (p == 0) ? (r0_read | r0_write) : (r1_read | r1_write);
    endfunction

    function automatic logic [31:0] rdat(input int p);
        return (p == 0) ? r0_readdata : r1_readdata;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        wr;
        logic        hung;
        logic [31:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] ref_mem [64];
    logic        sb_on = 1'b0;
    logic        flag_exp = 1'b0;

    always @(negedge clk) begin
        if (sb_on) begin
            logic nflag;
            exp_t e;
            #2;
            check("flag", {31'b0, timeout_flag}, {31'b0, flag_exp});
            nflag = flag_exp;
            if (timeout_clear) nflag = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (rq(p) && !wq(p)) begin
                    if ((p == 0 ? q0.size() : q1.size()) == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL sb_empty: port %0d completed with no expected entry", p);
                    end else begin
                        e = (p == 0) ? q0.pop_front() : q1.pop_front();
                        if (e.hung) begin
                            check("abort_data", rdat(p), TDATA);
                            nflag = 1'b1;
                        end else if (!e.wr) begin
                            check("read_data", rdat(p), e.data);
                        end
                    end
                end
            end
            flag_exp = nflag;
        end
    end

    logic drv_done [2];

    task automatic drive(input int p);
        exp_t        e;
        logic [31:0] a, d;
        logic        wr, done;
        int          cnt;
        for (int n = 0; n < NTX; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a  = 32'(p * 32) + 32'($urandom_range(0, 31));
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            e.wr   = wr;
            e.hung = (stall_of[a[5:0]] >= TO);
            e.data = e.hung ? TDATA : ref_mem[a[5:0]];
            if (wr && !e.hung) ref_mem[a[5:0]] = d;
            if (p == 0) q0.push_back(e);
            else        q1.push_back(e);
            set_req(p, ~wr, wr, a, d);
            cnt = 0;
            do begin
                #1;
                done = !wq(p);
                @(negedge clk);
                cnt++;
            end while (!done && cnt < 200);
            if (!done) begin
                vectors++;
                miscompares++;
                $display("FAIL drv_timeout: port %0d got no response, required within 200 cycles", p);
            end
            set_req(p, 1'b0, 1'b0, a, d);
        end
        drv_done[p] = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] w0, w1;
        int         nw, drop;
        logic       any0, fl_ab, mr;
        logic [31:0] rd;

        for (int i = 0; i < 64; i++) begin
            init_mem[i] = $urandom;
            stall_of[i] = 0;
        end
        init_mem[16] = 32'h84;
        stall_of[3]  = 5;
        stall_of[7]  = 100;
        drv_done[0]  = 1'b0;
        drv_done[1]  = 1'b0;

        // reset values
        #1;
        check("rst_r0_wait", {31'b0, r0_waitrequest}, 1);
        check("rst_r1_wait", {31'b0, r1_waitrequest}, 1);
        check("rst_r0_rdata", r0_readdata, 0);
        check("rst_r1_rdata", r1_readdata, 0);
        check("rst_m_rdwr", {30'b0, m_read, m_write}, 0);
        check("rst_flag", {31'b0, timeout_flag}, 0);
        load_mem();
        do_reset();

        // single read without stall
        set_req(0, 1'b1, 1'b0, 32'h10, 0);
        #1;
        check("rd_c0_wait", {31'b0, r0_waitrequest}, 1);
        check("rd_c0_mread", {31'b0, m_read}, 0);
        @(negedge clk); #1;
        check("rd_c1_mread", {31'b0, m_read}, 1);
        check("rd_c1_maddr", m_address, 32'h10);
        check("rd_c1_wait", {31'b0, r0_waitrequest}, 0);
        check("rd_c1_data", r0_readdata, 32'h84);
        @(negedge clk); #1;
        check("rd_c2_mread", {31'b0, m_read}, 0);
        check("rd_c2_wait", {31'b0, r0_waitrequest}, 1);
        idle_all();

        // both continuously active from reset: r0, r1, r0, r1
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'd1, 0);
        set_req(1, 1'b1, 1'b0, 32'd2, 0);
        for (int c = 0; c < 8; c++) begin
            #1;
            w0[c] = ~r0_waitrequest;
            w1[c] = ~r1_waitrequest;
            @(negedge clk);
        end
        idle_all();
        check("rr_r0_pattern", {24'b0, w0}, 32'h22);
        check("rr_r1_pattern", {24'b0, w1}, 32'h88);

        // r1 write with 5 stall cycles
        set_req(1, 1'b0, 1'b1, 32'd3, 32'h5A);
        nw = 0; drop = -1; any0 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (m_write) nw++;
            if (!r1_waitrequest && drop < 0) drop = c;
            if (!r0_waitrequest) any0 = 1'b1;
            @(negedge clk);
            if (drop >= 0) r1_write = 1'b0;
        end
        check("wr_mwrite_cycles", nw, 6);
        check("wr_drop_cycle", drop, 6);
        check("wr_r0_stalled", {31'b0, any0}, 0);
        check("wr_mem", mem[3], 32'h5A);

        // watchdog abort on stuck slave
        set_req(0, 1'b1, 1'b0, 32'd7, 0);
        drop = -1; rd = '0; mr = 1'b1; fl_ab = 1'b1;
        for (int c = 0; c < 14 && drop < 0; c++) begin
            #1;
            if (!r0_waitrequest) begin
                drop = c; rd = r0_readdata; mr = m_read; fl_ab = timeout_flag;
            end
            @(negedge clk);
        end
        r0_read = 1'b0;
        check("to_drop_cycle", drop, 8);
        check("to_data", rd, TDATA);
        check("to_mread", {31'b0, mr}, 0);
        check("to_flag_same", {31'b0, fl_ab}, 0);
        #1;
        check("to_flag_next", {31'b0, timeout_flag}, 1);
        @(negedge clk);
        timeout_clear = 1'b1;
        @(negedge clk);
        timeout_clear = 1'b0;
        #1;
        check("to_flag_clr", {31'b0, timeout_flag}, 0);

        // reset during stalled r1 read
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 32'd7, 0);
        repeat (3) @(negedge clk);
        #1;
        check("rstb_mread_pre", {31'b0, m_read}, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rstb_mread", {31'b0, m_read}, 0);
        idle_all();
        @(negedge clk);
        reset = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'd1, 0);
        set_req(1, 1'b1, 1'b0, 32'd2, 0);
        @(negedge clk); #1;
        check("rstb_first_r0", {30'b0, r1_waitrequest, r0_waitrequest}, 2'b10);
        @(negedge clk);
        idle_all();

        // r0 withdraws mid-BUSY while r1 waits
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'd7, 0);
        set_req(1, 1'b1, 1'b0, 32'd2, 0);
        @(negedge clk); #1;
        check("wd_c1_maddr", m_address, 32'd7);
        @(negedge clk);
        r0_read = 1'b0;
        #1;
        check("wd_c2_mread", {31'b0, m_read}, 0);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 32'd1, 0);
        for (int c = 0; c < 8; c++) begin
            #1;
            w0[c] = ~r0_waitrequest;
            w1[c] = ~r1_waitrequest;
            @(negedge clk);
        end
        idle_all();
        check("wd_r0_pattern", {24'b0, w0}, 32'h22);
        check("wd_r1_pattern", {24'b0, w1}, 32'h88);

        // randomized traffic
        for (int i = 0; i < 64; i++) begin
            init_mem[i] = $urandom;
            stall_of[i] = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(0, 3);
        end
        do_reset();
        load_mem();
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        flag_exp = 1'b0;
        sb_on = 1'b1;
        fork
            drive(0);
            drive(1);
            begin
                while (!(drv_done[0] && drv_done[1])) begin
                    @(negedge clk);
                    timeout_clear = ($urandom_range(0, 15) == 0);
                end
                timeout_clear = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        sb_on = 1'b0;
        #3;
        check("sb_q0_left", q0.size(), 0);
        check("sb_q1_left", q1.size(), 0);
        for (int i = 0; i < 64; i++) check("mem_final", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
